usart_rx_frame: RTL and testbench
=================================

// Module: usart_rx_frame
// PURPOSE
//  Receive-side frame engine of the USART, directly downstream of the RX falling-edge detector.
//  Consumes the one-cycle start-edge pulse plus the synchronised RX line and 16x baud ticks.
//  Validates the start bit, shifts in the data bits LSB first, and checks optional parity and the stop bit.
//  Presents each byte to the CPU side through a valid/read handshake with frame/parity/overrun status.
// PARAMETERS
//  DATA_BITS   8   data bits per frame (5..9)
//  OVERSAMPLE  16  baud_tick pulses per bit period (even, >=8)
//  PARITY_EN   0   1 = one parity bit follows the data bits
//  PARITY_ODD  0   1 = odd parity, 0 = even parity (used only when PARITY_EN=1)
// PORTS
//  CPU_Clk      in   1          single system clock, rising edge
//  CPU_Rst_n    in   1          asynchronous, active-low reset
//  baud_tick    in   1          1-cycle strobe, OVERSAMPLE per bit period
//  start_edge   in   1          1-cycle pulse from RX falling-edge detector
//  rx_in        in   1          synchronised RX line, idle high
//  rx_read      in   1          CPU consumes rx_data this cycle
//  rx_data      out  DATA_BITS  last received byte
//  rx_valid     out  1          rx_data unread
//  rx_busy      out  1          frame in progress (state != IDLE)
//  frame_err    out  1          stop bit of last frame sampled low
//  parity_err   out  1          parity mismatch in last frame
//  overrun_err  out  1          frame completed while rx_valid was still set
// BEHAVIOUR
//  - Reset (async, CPU_Rst_n=0): state=IDLE; all counters 0; every output 0. Reset mid-frame aborts the frame with no flags.
//  - Clock and reset: one clock (CPU_Clk); reset is asynchronous and active-low (CPU_Rst_n).
//  - FSM states: IDLE, START, DATA, PARITY, STOP.
//  - IDLE: start_edge=1 -> START, tick_cnt=0. start_edge in any other state is ignored.
//  - START: count baud_tick; on tick number OVERSAMPLE/2 sample rx_in.
//    rx_in=0 -> DATA, tick_cnt=0, bit_cnt=0. rx_in=1 -> IDLE (false start, no flags, nothing stored).
//  - DATA: sample rx_in every OVERSAMPLE ticks (mid-bit) into a shift register, LSB first.
//    After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
//  - PARITY: sample after OVERSAMPLE ticks. Mismatch: XOR(data, parity bit) != PARITY_ODD -> parity_err_next=1.
//  - STOP: sample after OVERSAMPLE ticks; rx_in=0 -> frame_err_next=1. Then -> IDLE immediately (mid stop bit),
//    so a start_edge arriving in the second half of the stop bit is accepted.
//  - Completion (the cycle of the stop sample):
//    - rx_data, frame_err and parity_err are loaded from this frame; rx_valid=1 from the next cycle.
//    - rx_data is loaded even when frame_err=1.
//  - Handshake:
//    - rx_read with rx_valid=1 clears rx_valid and overrun_err next cycle.
//    - rx_read with rx_valid=0 is a no-op.
//  - Overrun: if a frame completes while rx_valid=1 and rx_read=0, then overrun_err=1 (sticky until rx_read)
//    and the new data overwrites rx_data.
//  - Simultaneous completion + rx_read: the new frame wins; rx_valid stays 1; overrun_err is cleared, not set.
//  - Counters: tick_cnt is $clog2(OVERSAMPLE) bits, wraps at OVERSAMPLE-1 -> 0. bit_cnt is $clog2(DATA_BITS+1) bits.
//  - Counters advance only on baud_tick; with no ticks the FSM holds its state.
//  - Latency: rx_valid rises 1 cycle after the stop-bit sample; no combinational path from inputs to outputs.
// STRUCTURE
//  - Shared include usart_defs.vh: FSM state encodings and default DATA_BITS/OVERSAMPLE.
//    The TX path reuses these.
//  - One natural sub-module: usart_bit_timer.
//    Counts baud_tick pulses and emits mid_pulse (tick OVERSAMPLE/2) and bit_pulse (tick OVERSAMPLE).
//    It has a clear input.
//  - FSM, shift register and status registers stay in this module.
// TESTING
//  1. Frame 0x55, 8N1, 16x ticks:
//     rx_data=0x55, rx_valid=1 one cycle after the stop sample, all error flags 0.
//  2. Glitch: start_edge, then rx_in high again before tick 8:
//     FSM returns to IDLE, rx_busy falls, rx_valid stays 0.
//  3. Frame 0xA3 with stop bit driven low:
//     rx_data=0xA3, frame_err=1, rx_valid=1.
//  4. PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0:
//     parity_err=1. Same frame with parity bit 1: parity_err=0.
//  5. Two frames 0x11 then 0x22 with no rx_read:
//     rx_data=0x22, overrun_err=1. Then rx_read: rx_valid=0, overrun_err=0.
//  6. Reset in the middle of bit 4: all outputs 0, state IDLE.
//     A following frame 0x3C is received cleanly.
//     Also: rx_read in the same cycle as completion -> rx_valid stays 1, overrun_err=0.

Source files
------------

// File: rtl/usart_rx_frame_pkg.sv
// Shared USART definitions: FSM state encodings and default frame geometry.
// The TX path imports the same package so both directions agree on encodings.
package usart_rx_frame_pkg;

  // Default frame geometry.
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  // Frame FSM encodings. These stay plain constants so legacy code that
  // compares raw state vectors keeps working.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/usart_bit_timer.sv
// Baud-tick counter for one bit period.
// mid_pulse marks tick OVERSAMPLE/2 after a clear and is used to qualify the
// start bit. bit_pulse marks tick OVERSAMPLE, which lands mid-bit once the
// counter has been re-aligned on the start-bit centre.
module usart_bit_timer
  import usart_rx_frame_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic CPU_Clk,
  input  logic CPU_Rst_n,
  input  logic baud_tick,
  input  logic clear,
  output logic mid_pulse,
  output logic bit_pulse
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID_LAST = TW'(OVERSAMPLE/2 - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(OVERSAMPLE - 1);

  logic [TW-1:0] tick_cnt;

  // Pulses coincide with the tick that completes the count. They are not
  // gated by clear: the owner derives clear from mid_pulse.
  assign mid_pulse = baud_tick && (tick_cnt == MID_LAST);
  assign bit_pulse = baud_tick && (tick_cnt == BIT_LAST);

  // Tick counter: held at zero while cleared, wraps after the last tick of a bit.
  always_ff @(posedge CPU_Clk or negedge CPU_Rst_n) begin
    if (!CPU_Rst_n) begin
      tick_cnt <= '0;
    end else if (clear) begin
      tick_cnt <= '0;
    end else if (baud_tick) begin
      tick_cnt <= (tick_cnt == BIT_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usart_rx_frame.sv
// USART receive frame engine.
// Qualifies the start bit, shifts data in LSB first, checks optional parity
// and the stop bit, then hands the byte to the CPU through a valid/read
// handshake with frame, parity and overrun status. All outputs are registered
// or decoded from registered state only.
module usart_rx_frame
  import usart_rx_frame_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 CPU_Clk,
  input  logic                 CPU_Rst_n,
  input  logic                 baud_tick,
  input  logic                 start_edge,
  input  logic                 rx_in,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic [2:0]           state;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err_pend;
  logic                 mid_pulse;
  logic                 bit_pulse;
  logic                 timer_clr;
  logic                 frame_done;

  // The timer idles at zero, starts counting with the start edge and is
  // re-aligned on the start-bit centre so every later bit_pulse is mid-bit.
  assign timer_clr  = (state == ST_IDLE) || ((state == ST_START) && mid_pulse);
  assign frame_done = (state == ST_STOP) && bit_pulse;
  assign rx_busy    = (state != ST_IDLE);

  usart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .CPU_Clk   (CPU_Clk),
    .CPU_Rst_n (CPU_Rst_n),
    .baud_tick (baud_tick),
    .clear     (timer_clr),
    .mid_pulse (mid_pulse),
    .bit_pulse (bit_pulse)
  );

  // Frame FSM with the data shift register and the pending parity result.
  always_ff @(posedge CPU_Clk or negedge CPU_Rst_n) begin
    if (!CPU_Rst_n) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      par_err_pend <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_edge) begin
            state        <= ST_START;
            par_err_pend <= 1'b0;
          end
        end
        ST_START: begin
          // A line that is high again at the start-bit centre was a glitch.
          if (mid_pulse) begin
            state   <= rx_in ? ST_IDLE : ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (bit_pulse) begin
            shift_reg <= {rx_in, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= PARITY_EN ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_pulse) begin
            par_err_pend <= ((^shift_reg) ^ rx_in) != PARITY_ODD;
            state        <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leave mid stop bit so a start edge in its second half is caught.
          if (bit_pulse) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Received byte and per-frame status, loaded on the stop-bit sample.
  always_ff @(posedge CPU_Clk or negedge CPU_Rst_n) begin
    if (!CPU_Rst_n) begin
      rx_data    <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else if (frame_done) begin
      rx_data    <= shift_reg;
      frame_err  <= ~rx_in;
      parity_err <= PARITY_EN && par_err_pend;
    end
  end

  // CPU handshake. A completing frame always wins over a read in the same
  // cycle; overrun is only raised when unread data is overwritten.
  always_ff @(posedge CPU_Clk or negedge CPU_Rst_n) begin
    if (!CPU_Rst_n) begin
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_done) begin
        rx_valid <= 1'b1;
      end else if (rx_read) begin
        rx_valid <= 1'b0;
      end

      if (rx_read && rx_valid) begin
        overrun_err <= 1'b0;
      end else if (frame_done && rx_valid) begin
        overrun_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usart_rx_frame.sv
// Directed bench for usart_rx_frame: an 8N1 instance and an 8E1 instance
// share the line and tick stimulus; each has its own start edge and read.
module tb_usart_rx_frame;

  logic       clk;
  logic       rst_n;
  logic       baud_tick;
  logic       rx_in;
  logic       start_edge;
  logic       start_edge_p;
  logic       rx_read;
  logic       rx_read_p;

  logic [7:0] rx_data,  rx_data_p;
  logic       rx_valid, rx_valid_p;
  logic       rx_busy,  rx_busy_p;
  logic       frame_err, frame_err_p;
  logic       parity_err, parity_err_p;
  logic       overrun_err, overrun_err_p;

  int checks = 0;
  int errors = 0;
  logic pre_valid;

  usart_rx_frame #(
    .DATA_BITS (8), .OVERSAMPLE (16), .PARITY_EN (1'b0), .PARITY_ODD (1'b0)
  ) u_dut (
    .CPU_Clk     (clk),
    .CPU_Rst_n   (rst_n),
    .baud_tick   (baud_tick),
    .start_edge  (start_edge),
    .rx_in       (rx_in),
    .rx_read     (rx_read),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_busy     (rx_busy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err)
  );

  usart_rx_frame #(
    .DATA_BITS (8), .OVERSAMPLE (16), .PARITY_EN (1'b1), .PARITY_ODD (1'b0)
  ) u_dut_p (
    .CPU_Clk     (clk),
    .CPU_Rst_n   (rst_n),
    .baud_tick   (baud_tick),
    .start_edge  (start_edge_p),
    .rx_in       (rx_in),
    .rx_read     (rx_read_p),
    .rx_data     (rx_data_p),
    .rx_valid    (rx_valid_p),
    .rx_busy     (rx_busy_p),
    .frame_err   (frame_err_p),
    .parity_err  (parity_err_p),
    .overrun_err (overrun_err_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One baud tick, one clock wide, driven on the falling edge.
  task automatic tick();
    @(negedge clk); baud_tick = 1'b1;
    @(negedge clk); baud_tick = 1'b0;
  endtask

  task automatic drive_line(input logic v, input int n);
    rx_in = v;
    repeat (n) tick();
  endtask

  task automatic read_pulse(input bit use_p);
    @(negedge clk);
    if (use_p) rx_read_p = 1'b1; else rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0; rx_read_p = 1'b0;
  endtask

  // Full frame up to and including the stop-bit sample (8th stop tick).
  // pre_v is rx_valid just before that sample; rd_last reads in the same cycle.
  task automatic send_frame(input logic [7:0] data, input bit use_p, input logic par_bit,
                            input logic stop_bit, input bit rd_last, output logic pre_v);
    @(negedge clk);
    rx_in = 1'b0;
    if (use_p) start_edge_p = 1'b1; else start_edge = 1'b1;
    @(negedge clk);
    start_edge = 1'b0; start_edge_p = 1'b0;
    drive_line(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_line(data[i], 16);
    if (use_p) drive_line(par_bit, 16);
    drive_line(stop_bit, 7);
    pre_v = use_p ? rx_valid_p : rx_valid;
    @(negedge clk);
    baud_tick = 1'b1;
    if (rd_last) rx_read = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0; rx_read = 1'b0;
    rx_in = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; baud_tick = 1'b0; rx_in = 1'b1;
    start_edge = 1'b0; start_edge_p = 1'b0; rx_read = 1'b0; rx_read_p = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_valid", rx_valid, 0);
    chk("reset_busy", rx_busy, 0);
    chk("reset_data", rx_data, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 0x55 8N1
    send_frame(8'h55, 0, 1'b0, 1'b1, 0, pre_valid);
    chk("t1_pre_valid", pre_valid, 0);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 8'h55);
    chk("t1_frame_err", frame_err, 0);
    chk("t1_parity_err", parity_err, 0);
    chk("t1_overrun", overrun_err, 0);
    drive_line(1'b1, 8);
    read_pulse(0);
    chk("t1_read_valid", rx_valid, 0);

    // 2: start glitch, line back high before the start-bit centre
    @(negedge clk); rx_in = 1'b0; start_edge = 1'b1;
    @(negedge clk); start_edge = 1'b0;
    chk("t2_busy", rx_busy, 1);
    drive_line(1'b0, 3);
    drive_line(1'b1, 5);
    chk("t2_idle", rx_busy, 0);
    chk("t2_valid", rx_valid, 0);
    drive_line(1'b1, 16);
    chk("t2_still_idle", rx_busy, 0);

    // 3: 0xA3 with stop bit low
    send_frame(8'hA3, 0, 1'b0, 1'b0, 0, pre_valid);
    chk("t3_data", rx_data, 8'hA3);
    chk("t3_frame_err", frame_err, 1);
    chk("t3_valid", rx_valid, 1);
    drive_line(1'b1, 8);
    read_pulse(0);

    // 4: even parity, 0x07 has three ones
    send_frame(8'h07, 1, 1'b0, 1'b1, 0, pre_valid);
    chk("t4_parity_bad", parity_err_p, 1);
    chk("t4_valid", rx_valid_p, 1);
    drive_line(1'b1, 8);
    read_pulse(1);
    send_frame(8'h07, 1, 1'b1, 1'b1, 0, pre_valid);
    chk("t4_parity_ok", parity_err_p, 0);
    chk("t4_data", rx_data_p, 8'h07);
    chk("t4_frame_err", frame_err_p, 0);
    drive_line(1'b1, 8);

    // 5: overrun
    send_frame(8'h11, 0, 1'b0, 1'b1, 0, pre_valid);
    drive_line(1'b1, 8);
    chk("t5_no_overrun_yet", overrun_err, 0);
    send_frame(8'h22, 0, 1'b0, 1'b1, 0, pre_valid);
    chk("t5_data", rx_data, 8'h22);
    chk("t5_overrun", overrun_err, 1);
    chk("t5_frame_err_clr", frame_err, 0);
    drive_line(1'b1, 8);
    read_pulse(0);
    chk("t5_read_valid", rx_valid, 0);
    chk("t5_read_overrun", overrun_err, 0);

    // 6: reset in the middle of bit 4, then a clean frame
    @(negedge clk); rx_in = 1'b0; start_edge = 1'b1;
    @(negedge clk); start_edge = 1'b0;
    drive_line(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_line(1'b1, 16);
    drive_line(1'b0, 8);
    chk("t6_busy_before", rx_busy, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", rx_busy, 0);
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_flags", {frame_err, parity_err, overrun_err}, 0);
    @(negedge clk); rst_n = 1'b1; rx_in = 1'b1;
    drive_line(1'b1, 16);
    chk("t6_idle_after", rx_busy, 0);
    send_frame(8'h3C, 0, 1'b0, 1'b1, 0, pre_valid);
    chk("t6_data", rx_data, 8'h3C);
    chk("t6_valid", rx_valid, 1);
    chk("t6_flags", {frame_err, parity_err, overrun_err}, 0);
    drive_line(1'b1, 8);

    // Read in the completion cycle: the new frame wins, no overrun
    send_frame(8'h5A, 0, 1'b0, 1'b1, 1, pre_valid);
    chk("t7_pre_valid", pre_valid, 1);
    chk("t7_valid", rx_valid, 1);
    chk("t7_overrun", overrun_err, 0);
    chk("t7_data", rx_data, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
